// File: rtl/win_pkg.sv
// win_pkg: shared types and constants for the 3x3 window generator.
package win_pkg;

   // RGB565 pixel {R[15:11], G[10:5], B[4:0]}
   typedef logic [15:0] pixel_t;

   // Packed window width: nine 16-bit taps
   localparam int WIN_W = 144;

   // Tap indices, row-major, 0 = top-left, 4 = centre
   localparam int TAP_TL = 0;
   localparam int TAP_TC = 1;
   localparam int TAP_TR = 2;
   localparam int TAP_ML = 3;
   localparam int TAP_MC = 4;
   localparam int TAP_MR = 5;
   localparam int TAP_BL = 6;
   localparam int TAP_BC = 7;
   localparam int TAP_BR = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } win_state_t;

   // Which sides of the current window fall outside the frame
   typedef struct packed {
      logic top;
      logic bottom;
      logic left;
      logic right;
   } mask_t;

   // True when a tap lies on a masked side of the window
   function automatic logic tap_masked(input mask_t m, input int tap);
      return ((tap / 3) == 0 && m.top)  || ((tap / 3) == 2 && m.bottom) ||
             ((tap % 3) == 0 && m.left) || ((tap % 3) == 2 && m.right);
   endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image line of pixels, one write port and one read port,
// read data registered (one-cycle latency) so it maps onto block RAM.
module line_buffer
   import win_pkg::*;
#(
   parameter int DEPTH = 320,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  pixel_t        wr_data,
   input  logic [AW-1:0] rd_addr,
   output pixel_t        rd_data
);

   pixel_t mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Registered read port
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/window3x3_gen.sv
// window3x3_gen: streaming 3x3 neighbourhood generator for RGB565 video.
// Build macro WIN_EDGE_REPLICATE_EN: when defined, out-of-frame taps copy the
// nearest in-frame pixel (rows first, then columns); otherwise they are zero.
module window3x3_gen
   import win_pkg::*;
#(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240
) (
   input  logic             d_clk,
   input  logic             d_rst_n,
   input  logic             vsync,
   input  logic [15:0]      pix_in,
   input  logic             pix_valid,
   output logic [WIN_W-1:0] RGB_data,
   output logic             valid_out,
   output logic             out_vsync,
   output logic             frame_done,
   output logic             overrun_err
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   win_state_t    state_reg, state_next;
   logic [CW-1:0] in_col_reg, in_col_next, out_col_reg, out_col_next;
   logic [RW-1:0] in_row_reg, in_row_next, out_row_reg, out_row_next;
   logic          overrun_next;

   // Shift registers hold the two older columns of each window row
   pixel_t t1_reg, t2_reg, m1_reg, m2_reg, b1_reg, b2_reg;
   pixel_t cur_t, cur_m, cur_b;

   logic   accept, step, emit;
   logic   in_last_col, in_last_row, out_last_col, out_last_row, last_win;
   mask_t  mask;
   pixel_t raw_tap [9];
   pixel_t win_tap [9];
   logic [WIN_W-1:0] window_bus;

   // A pixel is taken outside FLUSH; FLUSH steps the pipeline with dummy data
   assign accept = pix_valid && !vsync && (state_reg != ST_FLUSH);
   assign step   = accept || (!vsync && state_reg == ST_FLUSH);
   assign emit   = (accept && state_reg == ST_RUN) || (!vsync && state_reg == ST_FLUSH);

   assign in_last_col  = (in_col_reg  == CW'(IMG_WIDTH - 1));
   assign in_last_row  = (in_row_reg  == RW'(IMG_HEIGHT - 1));
   assign out_last_col = (out_col_reg == CW'(IMG_WIDTH - 1));
   assign out_last_row = (out_row_reg == RW'(IMG_HEIGHT - 1));
   assign last_win     = out_last_col && out_last_row;

   // Next state, input/output position counters and the sticky overrun flag
   always_comb begin
      state_next   = state_reg;
      in_col_next  = in_col_reg;
      in_row_next  = in_row_reg;
      out_col_next = out_col_reg;
      out_row_next = out_row_reg;
      overrun_next = overrun_err;
      if (vsync) begin
         state_next   = ST_IDLE;
         in_col_next  = '0;
         in_row_next  = '0;
         out_col_next = '0;
         out_row_next = '0;
         overrun_next = 1'b0;
      end else begin
         if (step) begin
            if (in_last_col) begin
               in_col_next = '0;
               in_row_next = in_last_row ? '0 : in_row_reg + RW'(1);
            end else begin
               in_col_next = in_col_reg + CW'(1);
            end
         end
         if (emit) begin
            if (out_last_col) begin
               out_col_next = '0;
               out_row_next = out_last_row ? '0 : out_row_reg + RW'(1);
            end else begin
               out_col_next = out_col_reg + CW'(1);
            end
         end
         case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_FILL;
            ST_FILL:  if (accept && in_row_reg == RW'(1) && in_col_reg == '0)
                         state_next = ST_RUN;
            ST_RUN:   if (accept && in_last_col && in_last_row)
                         state_next = ST_FLUSH;
            ST_FLUSH: begin
               if (pix_valid)
                  overrun_next = 1'b1;
               if (last_win) begin
                  state_next  = ST_IDLE;
                  in_col_next = '0;
                  in_row_next = '0;
               end
            end
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // State and counter registers
   always_ff @(posedge d_clk or negedge d_rst_n) begin
      if (!d_rst_n) begin
         state_reg   <= ST_IDLE;
         in_col_reg  <= '0;
         in_row_reg  <= '0;
         out_col_reg <= '0;
         out_row_reg <= '0;
      end else begin
         state_reg   <= state_next;
         in_col_reg  <= in_col_next;
         in_row_reg  <= in_row_next;
         out_col_reg <= out_col_next;
         out_row_reg <= out_row_next;
      end
   end

   // Line buffers: lb_mid delays by one line, lb_top by two. Reading the
   // address that will be written next hides the one-cycle RAM latency.
   assign cur_b = (state_reg == ST_FLUSH) ? '0 : pix_in;

   line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) lb_mid (
      .clk     (d_clk),
      .wr_en   (step),
      .wr_addr (in_col_reg),
      .wr_data (cur_b),
      .rd_addr (in_col_next),
      .rd_data (cur_m)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) lb_top (
      .clk     (d_clk),
      .wr_en   (step),
      .wr_addr (in_col_reg),
      .wr_data (cur_m),
      .rd_addr (in_col_next),
      .rd_data (cur_t)
   );

   // Shift the three window rows one column on every pipeline step
   always_ff @(posedge d_clk or negedge d_rst_n) begin
      if (!d_rst_n) begin
         t1_reg <= '0;
         t2_reg <= '0;
         m1_reg <= '0;
         m2_reg <= '0;
         b1_reg <= '0;
         b2_reg <= '0;
      end else if (step) begin
         t2_reg <= t1_reg;
         t1_reg <= cur_t;
         m2_reg <= m1_reg;
         m1_reg <= cur_m;
         b2_reg <= b1_reg;
         b1_reg <= cur_b;
      end
   end

   assign raw_tap[TAP_TL] = t2_reg;
   assign raw_tap[TAP_TC] = t1_reg;
   assign raw_tap[TAP_TR] = cur_t;
   assign raw_tap[TAP_ML] = m2_reg;
   assign raw_tap[TAP_MC] = m1_reg;
   assign raw_tap[TAP_MR] = cur_m;
   assign raw_tap[TAP_BL] = b2_reg;
   assign raw_tap[TAP_BC] = b1_reg;
   assign raw_tap[TAP_BR] = cur_b;

   assign mask.top    = (out_row_reg == '0);
   assign mask.bottom = out_last_row;
   assign mask.left   = (out_col_reg == '0);
   assign mask.right  = out_last_col;

`ifdef WIN_EDGE_REPLICATE_EN
   pixel_t row_tap [9];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_tap
`ifdef WIN_EDGE_REPLICATE_EN
         localparam int ROW = gi / 3;
         localparam int COL = gi % 3;
         // Row padding first (copy middle row), then column padding (copy centre column)
         assign row_tap[gi] = ((ROW == 0 && mask.top) || (ROW == 2 && mask.bottom)) ?
                              raw_tap[TAP_ML + COL] : raw_tap[gi];
         assign win_tap[gi] = ((COL == 0 && mask.left) || (COL == 2 && mask.right)) ?
                              row_tap[ROW * 3 + 1] : row_tap[gi];
`else
         assign win_tap[gi] = tap_masked(mask, gi) ? '0 : raw_tap[gi];
`endif
         assign window_bus[WIN_W-1-16*gi -: 16] = win_tap[gi];
      end
   endgenerate

   // Registered outputs
   always_ff @(posedge d_clk or negedge d_rst_n) begin
      if (!d_rst_n) begin
         RGB_data    <= '0;
         valid_out   <= 1'b0;
         out_vsync   <= 1'b0;
         frame_done  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         valid_out   <= emit;
         frame_done  <= emit && last_win;
         out_vsync   <= vsync;
         overrun_err <= overrun_next;
         if (emit)
            RGB_data <= window_bus;
      end
   end

endmodule
